// File: rtl/beamform_pkg.sv
// Shared constants, types and the beam delay table for the L1 power trigger.
// Imported by beam_power and beam_power_trigger.
package beamform_pkg;

    localparam int NCHAN       = 8;
    localparam int NSAMP       = 8;
    localparam int SAMPLE_BITS = 5;
    localparam int POWER_BITS  = 18;
    localparam int MAXDELAY    = 15;

    localparam int BEAM_BITS = 8;
    localparam int SQ_BITS   = 15;
    localparam int DLY_BITS  = 4;

    // Three words of history per channel: current plus two previous.
    localparam int HIST_SAMP = 3 * NSAMP;
    localparam int HIST_BITS = HIST_SAMP * SAMPLE_BITS;
    localparam int WORD_BITS = NSAMP * SAMPLE_BITS;

    // Larger than any reachable window power, so nothing fires after reset.
    localparam logic [POWER_BITS-1:0] THRESH_RST = '1;

    typedef logic [NCHAN-1:0][DLY_BITS-1:0] delay_row_t;
    typedef logic [NCHAN-1:0][HIST_BITS-1:0] hist_t;

    // D[b][c] = (b*c) mod 16; beam 0 is all zero and beam 1 is D=c.
    function automatic delay_row_t beam_delays(input int b);
        delay_row_t r;
        r = '0;
        for (int c = 0; c < NCHAN; c++) begin
            r[c] = DLY_BITS'((b * c) % (MAXDELAY + 1));
        end
        return r;
    endfunction

    function automatic logic signed [BEAM_BITS-1:0] sext(
        input logic [SAMPLE_BITS-1:0] x
    );
        return signed'({{(BEAM_BITS-SAMPLE_BITS){x[SAMPLE_BITS-1]}}, x});
    endfunction

endpackage

// File: rtl/beam_power.sv
// One beam: delay-and-sum over 8 channels, square, 8-sample window power.
// Ports: clk_i/rst_i, hist_i (3-word history per channel), power_o (18b).
module beam_power
    import beamform_pkg::*;
#(
    parameter delay_row_t DELAYS = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  hist_t                 hist_i,
    output logic [POWER_BITS-1:0] power_o
);

    logic signed [BEAM_BITS-1:0] sum_d [NSAMP];
    logic signed [BEAM_BITS-1:0] sum_q [NSAMP];
    logic        [SQ_BITS-1:0]   sq_d  [NSAMP];
    logic        [SQ_BITS-1:0]   sq_q  [NSAMP];
    logic        [POWER_BITS-1:0] pow_d;
    logic        [POWER_BITS-1:0] pow_q;

    // Current word occupies history slots 16..23; a delay of up to 15
    // reaches back into slot 1 at the oldest.
    always_comb begin
        for (int i = 0; i < NSAMP; i++) begin
            sum_d[i] = '0;
            for (int c = 0; c < NCHAN; c++) begin
                sum_d[i] = sum_d[i] + sext(
                    hist_i[c][(2*NSAMP + i - int'(DELAYS[c]))*SAMPLE_BITS
                              +: SAMPLE_BITS]);
            end
        end
    end

    // Square fits in 15 bits (max 16384), so truncating the product is exact.
    always_comb begin
        for (int i = 0; i < NSAMP; i++) begin
            sq_d[i] = SQ_BITS'(sum_q[i] * sum_q[i]);
        end
    end

    always_comb begin
        pow_d = '0;
        for (int i = 0; i < NSAMP; i++) begin
            pow_d = pow_d + POWER_BITS'(sq_q[i]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NSAMP; i++) begin
                sum_q[i] <= '0;
                sq_q[i]  <= '0;
            end
            pow_q <= '0;
        end else begin
            for (int i = 0; i < NSAMP; i++) begin
                sum_q[i] <= sum_d[i];
                sq_q[i]  <= sq_d[i];
            end
            pow_q <= pow_d;
        end
    end

    assign power_o = pow_q;

endmodule

// File: rtl/beam_power_trigger.sv
// Per-beam power trigger: history, NBEAMS beam_power units, staged/active
// thresholds and strict compare. Ports: clk_i, rst_i, data_i, thresh_i,
// thresh_ce_i, update_i, trigger_o.
module beam_power_trigger
    import beamform_pkg::*;
#(
    parameter int NBEAMS = 2
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [NCHAN-1:0][WORD_BITS-1:0]    data_i,
    input  logic [POWER_BITS-1:0]              thresh_i,
    input  logic [NBEAMS-1:0]                  thresh_ce_i,
    input  logic                               update_i,
    output logic [NBEAMS-1:0]                  trigger_o
);

    logic [NCHAN-1:0][WORD_BITS-1:0] w0_q, w1_q, w2_q;
    hist_t                           hist;

    logic [NBEAMS-1:0][POWER_BITS-1:0] staged_d, staged_q;
    logic [NBEAMS-1:0][POWER_BITS-1:0] active_d, active_q;
    logic [NBEAMS-1:0]                 trig_d, trig_q;
    logic [POWER_BITS-1:0]             power [NBEAMS];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            w0_q <= '0;
            w1_q <= '0;
            w2_q <= '0;
        end else begin
            w0_q <= data_i;
            w1_q <= w0_q;
            w2_q <= w1_q;
        end
    end

    // Oldest word at the low bits so slot index follows stream order.
    always_comb begin
        for (int c = 0; c < NCHAN; c++) begin
            hist[c] = {w0_q[c], w1_q[c], w2_q[c]};
        end
    end

    for (genvar b = 0; b < NBEAMS; b++) begin : g_beam
        beam_power #(
            .DELAYS (beam_delays(b))
        ) u_beam_power (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .hist_i  (hist),
            .power_o (power[b])
        );
    end

    // Commit copies the pre-edge staged value, so a same-cycle stage
    // write lands only in staged.
    always_comb begin
        staged_d = staged_q;
        active_d = update_i ? staged_q : active_q;
        trig_d   = '0;
        for (int b = 0; b < NBEAMS; b++) begin
            if (thresh_ce_i[b]) begin
                staged_d[b] = thresh_i;
            end
            trig_d[b] = power[b] > active_q[b];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            staged_q <= {NBEAMS{THRESH_RST}};
            active_q <= {NBEAMS{THRESH_RST}};
            trig_q   <= '0;
        end else begin
            staged_q <= staged_d;
            active_q <= active_d;
            trig_q   <= trig_d;
        end
    end

    assign trigger_o = trig_q;

endmodule

// File: tb/tb_beam_power_trigger.sv
// Directed bench for beam_power_trigger with NBEAMS=2.
// Hand-computed window powers checked through the trigger output.
module tb_beam_power_trigger;

    logic              clk = 1'b0;
    logic              rst;
    logic [7:0][39:0]  data;
    logic [17:0]       thresh;
    logic [1:0]        ce;
    logic              upd;
    logic [1:0]        trig;

    int total = 0;
    int bad   = 0;

    beam_power_trigger #(
        .NBEAMS (2)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .data_i      (data),
        .thresh_i    (thresh),
        .thresh_ce_i (ce),
        .update_i    (upd),
        .trigger_o   (trig)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [1:0] got,
                       input logic [1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", tag, got, exp);
        end
    endtask

    task automatic set_all(input logic [4:0] v);
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < 8; i++) begin
                data[c][5*i +: 5] = v;
            end
        end
    endtask

    // Stage then commit one cycle later.
    task automatic load(input logic [1:0] mask, input logic [17:0] v);
        thresh = v;
        ce     = mask;
        tick();
        ce  = '0;
        upd = 1'b1;
        tick();
        upd = 1'b0;
    endtask

    initial begin
        rst    = 1'b1;
        data   = '0;
        thresh = '0;
        ce     = '0;
        upd    = 1'b0;
        tick();
        tick();
        chk("rst_trig", trig, 2'b00);

        // Constant +15: B=120, P=115200, thresholds still 3FFFF.
        rst = 1'b0;
        set_all(5'd15);
        repeat (10) tick();
        chk("rst_default", trig, 2'b00);
        repeat (20) tick();
        chk("rst_default_hold", trig, 2'b00);

        // Staging alone has no effect until commit.
        thresh = 18'd100000;
        ce     = 2'b01;
        tick();
        ce = '0;
        tick();
        chk("stage_only", trig, 2'b00);
        upd = 1'b1;
        tick();
        upd = 1'b0;
        chk("commit_edge", trig, 2'b00);
        tick();
        chk("commit", trig, 2'b01);
        repeat (5) tick();
        chk("commit_hold", trig, 2'b01);

        // Strict compare at P=115200.
        load(2'b01, 18'd115200);
        repeat (3) tick();
        chk("strict_eq", trig, 2'b00);
        load(2'b01, 18'd115199);
        repeat (3) tick();
        chk("strict_gt", trig, 2'b01);
        load(2'b10, 18'd115199);
        repeat (3) tick();
        chk("strict_both", trig, 2'b11);

        // Aligned impulse: beam 1 P=14400, beam 0 P=1800.
        load(2'b11, 18'd10000);
        set_all(5'd0);
        repeat (8) tick();
        chk("imp_quiet", trig, 2'b00);
        for (int c = 0; c < 8; c++) begin
            data[c][5*(7-c) +: 5] = 5'd15;
        end
        tick();
        data = '0;
        repeat (3) tick();
        chk("imp_pre", trig, 2'b00);
        tick();
        chk("imp_hit", trig, 2'b10);
        tick();
        chk("imp_post", trig, 2'b00);
        repeat (5) tick();
        chk("imp_after", trig, 2'b00);

        // All -16: B=-128, P=131072 on both beams.
        set_all(5'h10);
        load(2'b01, 18'd131072);
        repeat (8) tick();
        chk("neg_eq", trig, 2'b10);
        load(2'b01, 18'd131071);
        repeat (3) tick();
        chk("neg_max", trig, 2'b11);

        // Same-cycle stage and commit: active takes old staged (131071).
        thresh = 18'd131072;
        ce     = 2'b01;
        upd    = 1'b1;
        tick();
        ce  = '0;
        upd = 1'b0;
        repeat (3) tick();
        chk("simul_old", trig, 2'b11);
        upd = 1'b1;
        tick();
        upd = 1'b0;
        repeat (2) tick();
        chk("simul_commit", trig, 2'b10);

        // Reset while firing.
        load(2'b01, 18'd131071);
        repeat (2) tick();
        chk("pre_rst", trig, 2'b11);
        rst = 1'b1;
        tick();
        chk("rst_mid", trig, 2'b00);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("rst_refill", trig, 2'b00);
        end
        repeat (10) tick();
        chk("rst_thresh", trig, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
